// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and the
// load/store stage: one outstanding access, held until mem_ready or timeout.
module mem_port_arbiter #(
    parameter int TIMEOUT    = 64,
    parameter int MAX_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,

    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [3:0]  dm_mask,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,
    output logic        dm_err,

    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_mask,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int TW = $clog2(TIMEOUT);
    localparam int SW = $clog2(MAX_STREAK + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    state_t        state;
    logic [TW-1:0] tmo_cnt;
    logic [SW-1:0] streak;

    logic          sel_if;
    logic          sel_dm;
    logic          tmo_hit;
    logic          done;
    logic [31:0]   rsp_rdata;

    // NOTE: every variable gets a default before the if, so no latch is inferred.
    always_comb begin
        sel_if = 1'b0;
        sel_dm = 1'b0;
        // Grants are gated by rst so the asynchronous reset also silences them.
        if (rst && state == IDLE) begin
            if (dm_req && !(if_req && streak == SW'(MAX_STREAK)))
                sel_dm = 1'b1;
            else if (if_req)
                sel_if = 1'b1;
        end
    end

    assign if_gnt    = sel_if;
    assign dm_gnt    = sel_dm;
    assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT - 1));
    assign done      = mem_ready || tmo_hit;
    // A timeout or a completed store both return zero data.
    assign rsp_rdata = (mem_ready && !mem_we) ? mem_rdata : 32'h0;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            streak    <= '0;
            if_rvalid <= 1'b0;
            if_rdata  <= 32'h0;
            if_err    <= 1'b0;
            dm_rvalid <= 1'b0;
            dm_rdata  <= 32'h0;
            dm_err    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_mask  <= 4'h0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
        end else begin
            if_rvalid <= 1'b0;
            if_err    <= 1'b0;
            dm_rvalid <= 1'b0;
            dm_err    <= 1'b0;

            case (state)
                IDLE: begin
                    if (sel_dm) begin
                        state     <= BUSY_DM;
                        tmo_cnt   <= '0;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_mask  <= dm_mask;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        // A data grant with fetch waiting implies streak < MAX_STREAK.
                        streak    <= if_req ? streak + 1'b1 : '0;
                    end else if (sel_if) begin
                        state     <= BUSY_IF;
                        tmo_cnt   <= '0;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_mask  <= 4'hF;
                        mem_addr  <= if_addr;
                        mem_wdata <= 32'h0;
                        streak    <= '0;
                    end
                end

                BUSY_IF, BUSY_DM: begin
                    if (done) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        if (state == BUSY_IF) begin
                            if_rvalid <= 1'b1;
                            if_err    <= !mem_ready;
                            if_rdata  <= rsp_rdata;
                        end else begin
                            dm_rvalid <= 1'b1;
                            dm_err    <= !mem_ready;
                            dm_rdata  <= rsp_rdata;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int TIMEOUT    = 8;
    localparam int MAX_STREAK = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_gnt, if_rvalid, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_rvalid, dm_err;
    logic [3:0]  dm_mask;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_req, mem_we, mem_ready;
    logic [3:0]  mem_mask;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT(TIMEOUT), .MAX_STREAK(MAX_STREAK)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_mask(dm_mask), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
        .dm_rdata(dm_rdata), .dm_err(dm_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_mask(mem_mask),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the outstanding access (if any), the pending responses and the streak.
    typedef struct {
        bit          busy;
        bit          is_if;
        bit          we;
        logic [3:0]  mask;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waited;
    } access_t;

    access_t     acc;
    int          m_streak;
    bit          r_if_valid, r_if_err, r_dm_valid, r_dm_err;
    logic [31:0] r_if_data, r_dm_data;
    bit          last_if_gnt, last_dm_gnt;

    function automatic void model_reset();
        acc        = '{default: '0};
        m_streak   = 0;
        r_if_valid = 0; r_if_err = 0; r_if_data = '0;
        r_dm_valid = 0; r_dm_err = 0; r_dm_data = '0;
    endfunction

    function automatic void respond(input bit to_if, input bit err, input logic [31:0] data);
        if (to_if) begin
            r_if_valid = 1; r_if_err = err; r_if_data = data;
        end else begin
            r_dm_valid = 1; r_dm_err = err; r_dm_data = data;
        end
    endfunction

    always @(negedge clk) begin
        bit e_if_gnt, e_dm_gnt;
        if (!rst) model_reset();
        e_dm_gnt = rst && !acc.busy && dm_req && !(if_req && m_streak >= MAX_STREAK);
        e_if_gnt = rst && !acc.busy && if_req && !e_dm_gnt;

        check("if_gnt",    32'(if_gnt),    32'(e_if_gnt));
        check("dm_gnt",    32'(dm_gnt),    32'(e_dm_gnt));
        check("mem_req",   32'(mem_req),   32'(acc.busy));
        check("if_rvalid", 32'(if_rvalid), 32'(r_if_valid));
        check("if_err",    32'(if_err),    32'(r_if_err));
        check("if_rdata",  if_rdata,       r_if_data);
        check("dm_rvalid", 32'(dm_rvalid), 32'(r_dm_valid));
        check("dm_err",    32'(dm_err),    32'(r_dm_err));
        check("dm_rdata",  dm_rdata,       r_dm_data);
        if (acc.busy) begin
            check("mem_we",    32'(mem_we),   32'(acc.we));
            check("mem_mask",  32'(mem_mask), 32'(acc.mask));
            check("mem_addr",  mem_addr,      acc.addr);
            check("mem_wdata", mem_wdata,     acc.wdata);
        end

        if (rst) begin
            r_if_valid = 0; r_if_err = 0; r_dm_valid = 0; r_dm_err = 0;
            if (acc.busy) begin
                if (mem_ready) begin
                    respond(acc.is_if, 0, acc.we ? 32'h0 : mem_rdata);
                    acc.busy = 0;
                end else begin
                    acc.waited++;
                    if (acc.waited == TIMEOUT) begin
                        respond(acc.is_if, 1, 32'h0);
                        acc.busy = 0;
                    end
                end
            end else if (e_dm_gnt) begin
                acc = '{busy: 1, is_if: 0, we: dm_we, mask: dm_mask,
                        addr: dm_addr, wdata: dm_wdata, waited: 0};
                m_streak = if_req ? ((m_streak < MAX_STREAK) ? m_streak + 1 : m_streak) : 0;
            end else if (e_if_gnt) begin
                acc = '{busy: 1, is_if: 1, we: 0, mask: 4'hF,
                        addr: if_addr, wdata: 32'h0, waited: 0};
                m_streak = 0;
            end
        end
        last_if_gnt = e_if_gnt;
        last_dm_gnt = e_dm_gnt;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic dm_issue(input bit we, input logic [3:0] mask,
                            input logic [31:0] addr, input logic [31:0] wdata);
        dm_req = 1; dm_we = we; dm_mask = mask; dm_addr = addr; dm_wdata = wdata;
    endtask

    initial begin
        int          hi, n, seen, ready_pct;
        bit          got;
        logic [9:0]  seq;

        if_req = 0; if_addr = 0;
        dm_req = 0; dm_we = 0; dm_mask = 0; dm_addr = 0; dm_wdata = 0;
        mem_ready = 0; mem_rdata = 0;
        rst = 1;
        #1 rst = 0;
        #2;
        check("reset_mem_req",  32'(mem_req),  0);
        check("reset_mem_mask", 32'(mem_mask), 0);
        check("reset_if_rdata", if_rdata,      0);
        check("reset_dm_rvalid", 32'(dm_rvalid), 0);
        #19 rst = 1;

        // Fetch only, memory ready two cycles after mem_req rises.
        cyc(); if_req = 1; if_addr = 32'h100;
        #1 check("t1_if_gnt", 32'(if_gnt), 1);
        cyc(); if_req = 0;
        #1 check("t1_mem_req", 32'(mem_req), 1);
        check("t1_mem_addr", mem_addr, 32'h100);
        cyc();
        cyc(); mem_ready = 1; mem_rdata = 32'hDEADBEEF;
        cyc(); mem_ready = 0;
        #1 check("t1_if_rvalid", 32'(if_rvalid), 1);
        check("t1_if_rdata", if_rdata, 32'hDEADBEEF);
        check("t1_if_err", 32'(if_err), 0);

        // Store then load to 0x20; payload must hold while inputs change.
        cyc(); dm_issue(1, 4'b0011, 32'h20, 32'h0000ABCD);
        #1 check("t2_dm_gnt", 32'(dm_gnt), 1);
        cyc(); dm_req = 0; dm_we = 0; dm_wdata = 0; dm_mask = 0;
        #1 check("t2_mem_we", 32'(mem_we), 1);
        check("t2_mem_mask", 32'(mem_mask), 32'h3);
        cyc();
        #1 check("t2_mem_wdata_held", mem_wdata, 32'h0000ABCD);
        cyc(); mem_ready = 1;
        cyc(); mem_ready = 0; dm_issue(0, 4'hF, 32'h20, 32'h0);
        #1 check("t2_store_rvalid", 32'(dm_rvalid), 1);
        check("t2_store_rdata", dm_rdata, 32'h0);
        check("t2_load_gnt", 32'(dm_gnt), 1);
        cyc(); dm_req = 0; mem_ready = 1; mem_rdata = 32'h0000ABCD;
        cyc(); mem_ready = 0;
        #1 check("t2_load_rvalid", 32'(dm_rvalid), 1);
        check("t2_load_rdata", dm_rdata, 32'h0000ABCD);
        check("t2_if_rdata_held", if_rdata, 32'hDEADBEEF);

        // Contention with both requests held and an always-ready memory.
        cyc(); if_req = 1; if_addr = 32'h300; dm_issue(0, 4'hF, 32'h400, 32'h0);
        mem_ready = 1;
        n = 0; seq = '0;
        for (int c = 0; c < 40 && n < 10; c++) begin
            #1;
            if (dm_gnt || if_gnt) begin
                seq = {seq[8:0], if_gnt};
                n++;
            end
            cyc();
        end
        if_req = 0; dm_req = 0;
        check("t3_grant_count", n, 10);
        check("t3_grant_order", 32'(seq), 32'(10'b0000100001));
        cyc(); cyc(); mem_ready = 0;

        // Timeout after a data grant, then a fetch completes normally.
        cyc(); dm_issue(0, 4'hF, 32'h44, 32'h0);
        #1 check("t4_dm_gnt", 32'(dm_gnt), 1);
        cyc(); dm_req = 0;
        hi = 0; got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            #1;
            if (dm_rvalid) got = 1;
            else begin
                if (mem_req) hi++;
                cyc();
            end
        end
        check("t4_rvalid_seen", 32'(got), 1);
        check("t4_mem_req_cycles", hi, TIMEOUT);
        check("t4_dm_err", 32'(dm_err), 1);
        check("t4_dm_rdata", dm_rdata, 32'h0);
        check("t4_mem_req_low", 32'(mem_req), 0);
        if_req = 1; if_addr = 32'h200;
        #1 check("t4_if_gnt", 32'(if_gnt), 1);
        cyc(); if_req = 0; mem_ready = 1; mem_rdata = 32'h12345678;
        cyc(); mem_ready = 0;
        #1 check("t4_if_rvalid", 32'(if_rvalid), 1);
        check("t4_if_err", 32'(if_err), 0);
        check("t4_if_rdata", if_rdata, 32'h12345678);

        // Ready on the final timeout cycle wins over the abort.
        cyc(); dm_issue(0, 4'hF, 32'h48, 32'h0);
        cyc(); dm_req = 0;
        repeat (6) cyc();
        cyc(); mem_ready = 1; mem_rdata = 32'hCAFEF00D;
        #1 check("t5_mem_req_last", 32'(mem_req), 1);
        cyc(); mem_ready = 0;
        #1 check("t5_dm_rvalid", 32'(dm_rvalid), 1);
        check("t5_dm_err", 32'(dm_err), 0);
        check("t5_dm_rdata", dm_rdata, 32'hCAFEF00D);

        // Asynchronous reset in the middle of a store.
        cyc(); dm_issue(1, 4'hF, 32'h80, 32'h55);
        cyc(); dm_req = 0;
        cyc();
        #1 check("t6_busy_mem_req", 32'(mem_req), 1);
        #1 rst = 0; if_req = 1;
        #1 check("t6_rst_mem_req", 32'(mem_req), 0);
        check("t6_rst_mem_addr", mem_addr, 0);
        check("t6_rst_mem_wdata", mem_wdata, 0);
        check("t6_rst_if_gnt", 32'(if_gnt), 0);
        check("t6_rst_dm_rdata", dm_rdata, 0);
        check("t6_rst_if_rdata", if_rdata, 0);
        cyc(); cyc(); if_req = 0; mem_ready = 1;
        #2 rst = 1;
        seen = 0;
        repeat (6) begin
            cyc();
            #1 if (dm_rvalid) seen++;
        end
        check("t6_no_stale_rvalid", seen, 0);
        mem_ready = 0;
        dm_issue(0, 4'hF, 32'h90, 32'h0);
        #1 check("t6_new_gnt", 32'(dm_gnt), 1);
        cyc(); dm_req = 0; mem_ready = 1; mem_rdata = 32'h0BADF00D;
        cyc(); mem_ready = 0;
        #1 check("t6_new_rdata", dm_rdata, 32'h0BADF00D);

        // Randomized traffic; requesters hold until granted.
        ready_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            if (i % 250 == 0) begin
                case ($urandom_range(0, 3))
                    0: ready_pct = 90;
                    1: ready_pct = 50;
                    2: ready_pct = 15;
                    default: ready_pct = 3;
                endcase
            end
            if (!if_req || last_if_gnt) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!dm_req || last_dm_gnt) begin
                dm_req   = ($urandom_range(0, 2) != 0);
                dm_we    = $urandom_range(0, 1) != 0;
                dm_mask  = 4'($urandom);
                dm_addr  = $urandom;
                dm_wdata = $urandom;
            end
            mem_ready = ($urandom_range(0, 99) < ready_pct);
            mem_rdata = $urandom;
            if (i == 1500) #2 rst = 0;
            if (i == 1502) #2 rst = 1;
        end

        cyc(); if_req = 0; dm_req = 0; mem_ready = 1;
        repeat (4) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch requester and the memory-stage load/store requester.
- Sequences each access as a registered request that is held until the memory acknowledges it.
- Returns the response to the owning requester and ends hung accesses with a timeout error.
- Sits between the fetch/memory pipeline stages and the memory wrapper.

Parameters:
- TIMEOUT, 64: cycles a granted access may wait for mem_ready before it is aborted; minimum 2.
- MAX_STREAK, 4: maximum consecutive data grants while a fetch is pending; minimum 1.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  32  fetch address.
- if_gnt  out  1  one-cycle pulse; fetch request accepted.
- if_rvalid  out  1  one-cycle pulse; fetch response valid.
- if_rdata  out  32  fetch read data.
- if_err  out  1  qualifies if_rvalid; timeout occurred.
- dm_req  in  1  load/store request (load|store); held until dm_gnt.
- dm_we  in  1  1 = store.
- dm_mask  in  4  byte enables.
- dm_addr  in  32  data address.
- dm_wdata  in  32  store data.
- dm_gnt  out  1  one-cycle pulse; data request accepted.
- dm_rvalid  out  1  one-cycle pulse; load data valid or store complete.
- dm_rdata  out  32  load data.
- dm_err  out  1  qualifies dm_rvalid; timeout occurred.
- mem_req  out  1  request to memory.
- mem_we  out  1  write enable.
- mem_mask  out  4  byte enables.
- mem_addr  out  32  address.
- mem_wdata  out  32  write data.
- mem_ready  in  1  memory completes the access this cycle.
- mem_rdata  in  32  read data; valid when mem_ready=1 and mem_we=0.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including rdata buses.
  - Timeout counter and streak counter are 0.
- States: IDLE, BUSY_IF, BUSY_DM. Only one access is outstanding at any time.
- IDLE arbitration, evaluated each cycle:
  - dm_req only: select data.
  - if_req only: select fetch.
  - Both: select data unless streak == MAX_STREAK, in which case select fetch.
- On selection in cycle N:
  - Capture the requester payload into the mem_* registers.
  - Pulse the matching gnt in cycle N, combinationally from req and state.
  - mem_req=1 from cycle N+1.
  - Move to BUSY_IF or BUSY_DM.
  - For fetch: mem_we=0, mem_mask=4'hF, mem_wdata=0.
- Streak counter:
  - A data grant while if_req=1 increments it, saturating at MAX_STREAK.
  - Any fetch grant, or a data grant while if_req=0, clears it.
- BUSY state, mem_ready=1 in cycle M:
  - Deassert mem_req in cycle M+1.
  - Pulse the owner's rvalid in cycle M+1.
  - rdata is the registered mem_rdata for reads and 0 for stores.
  - err=0.
  - Return to IDLE in M+1; a new grant is possible in M+1.
  - Minimum occupancy: request N, memory ready N+1, response N+2.
- Timeout:
  - The counter clears on grant and increments each BUSY cycle with mem_ready=0.
  - When it reaches TIMEOUT-1 and mem_ready=0: next cycle deassert mem_req, pulse owner rvalid with err=1 and rdata=0, go to IDLE.
  - If mem_ready=1 on that same cycle, normal completion wins.
- mem_ready while IDLE is ignored.
- mem_* payload is stable for the whole mem_req=1 window.
- gnt is never asserted in BUSY states; requests wait.
- Only the owner's rvalid/rdata/err change; the other requester's rdata holds its last value.
- Reset mid-access: the access is dropped with no response and mem_req=0 immediately.

Test Plan:
- Fetch only: if_req=1, addr 0x100; mem_ready two cycles after mem_req rises, mem_rdata 0xDEADBEEF → if_gnt same cycle as the request; if_rvalid=1, if_rdata=0xDEADBEEF, if_err=0 one cycle after mem_ready.
- Store then load to 0x20: store dm_we=1, mask 4'b0011, wdata 0x0000ABCD; then load with mem_rdata 0x0000ABCD → mem_we/mask/wdata match the store and are held while waiting; store gets dm_rvalid with dm_rdata=0; load returns 0x0000ABCD.
- Contention: if_req and dm_req held continuously, MAX_STREAK=4, mem_ready=1 each busy cycle → grant order D,D,D,D,I,D,D,D,D,I.
- Timeout: TIMEOUT=8, mem_ready held 0 after a data grant → mem_req high exactly 8 cycles, then dm_rvalid=1, dm_err=1, dm_rdata=0, IDLE; a following fetch completes normally.
- Race: mem_ready=1 on the final timeout cycle → normal response, err=0.
- Async reset asserted mid-BUSY_DM → all outputs 0 without a clock edge; no dm_rvalid after rst=1; the next request gets a normal grant.
